// File: rtl/mosaic_pkg.sv
// mosaic_pkg: shared scan-controller types and defaults.
// Rev 1.0
`default_nettype none

package mosaic_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } scan_state_e;

  localparam int WIN_ROWS_DEF = 32;
  localparam int PIPE_LAT_DEF = 2;
  localparam int W_ROW_W      = 5;
  localparam int TAG_W        = 3;

  // Counter width that stays legal for degenerate sizes of 1.
  function automatic int safe_clog2(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/tag_pipe.sv
// tag_pipe: fixed-depth delay line for issue tags, cleared by a synchronous flush.
// Rev 1.0
`default_nettype none

module tag_pipe #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic [WIDTH-1:0] tag_i,
  output logic [WIDTH-1:0] tag_o
);

  logic [WIDTH-1:0] stage_q [DEPTH];

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
    end else if (flush_i) begin
      for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= tag_i;
      for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign tag_o = stage_q[DEPTH-1];

endmodule

`default_nettype wire

// File: rtl/scan_ctrl.sv
// scan_ctrl: walks window rows x POI rows x POI columns, one issue per ready cycle,
// and delays valid/last tags to line up with the RAM read data. Rev 1.0
`default_nettype none

module scan_ctrl
  import mosaic_pkg::*;
#(
  parameter int POI_ROWS = 16,
  parameter int POI_COLS = 16,
  parameter int WIN_ROWS = WIN_ROWS_DEF,
  parameter int PIPE_LAT = PIPE_LAT_DEF
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic                        abort,
  input  logic                        ready,
  output logic                        en,
  output logic [W_ROW_W-1:0]          w_row,
  output logic [$clog2(POI_ROWS)-1:0] POI_row,
  output logic [$clog2(POI_COLS)-1:0] POI_col,
  output logic                        busy,
  output logic                        done,
  output logic                        data_valid,
  output logic                        win_last,
  output logic                        frame_last
);

  localparam int PR_W  = $clog2(POI_ROWS);
  localparam int PC_W  = $clog2(POI_COLS);
  localparam int DRN_W = safe_clog2(PIPE_LAT);

  localparam logic [W_ROW_W-1:0] W_LAST   = W_ROW_W'(WIN_ROWS - 1);
  localparam logic [PR_W-1:0]    R_LAST   = PR_W'(POI_ROWS - 1);
  localparam logic [PC_W-1:0]    C_LAST   = PC_W'(POI_COLS - 1);
  localparam logic [DRN_W-1:0]   DRN_LAST = DRN_W'(PIPE_LAT - 1);

  scan_state_e        state_q;
  logic [W_ROW_W-1:0] w_row_q, w_row_d;
  logic [PR_W-1:0]    poi_row_q, poi_row_d;
  logic [PC_W-1:0]    poi_col_q, poi_col_d;
  logic [DRN_W-1:0]   drain_q;

  logic               issue;
  logic               w_wrap, r_wrap, c_wrap;
  logic               last_issue;
  logic [TAG_W-1:0]   tag_in, tag_out;

  assign issue      = (state_q == ST_RUN) && ready && !abort;
  assign w_wrap     = (w_row_q == W_LAST);
  assign r_wrap     = (poi_row_q == R_LAST);
  assign c_wrap     = (poi_col_q == C_LAST);
  assign last_issue = issue && w_wrap && r_wrap && c_wrap;

  // Wraps compare against the parameters so non-power-of-two grids walk correctly.
  always_comb begin
    w_row_d   = w_row_q;
    poi_row_d = poi_row_q;
    poi_col_d = poi_col_q;
    if ((state_q == ST_IDLE) && start && !abort) begin
      w_row_d   = '0;
      poi_row_d = '0;
      poi_col_d = '0;
    end else if (issue) begin
      w_row_d = w_wrap ? '0 : w_row_q + 1'b1;
      if (w_wrap) begin
        poi_row_d = r_wrap ? '0 : poi_row_q + 1'b1;
        if (r_wrap) poi_col_d = c_wrap ? '0 : poi_col_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      w_row_q   <= '0;
      poi_row_q <= '0;
      poi_col_q <= '0;
      drain_q   <= '0;
    end else begin
      w_row_q   <= w_row_d;
      poi_row_q <= poi_row_d;
      poi_col_q <= poi_col_d;
      if (abort) begin
        state_q <= ST_IDLE;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (start) state_q <= ST_RUN;
          end
          ST_RUN: begin
            if (last_issue) begin
              state_q <= ST_DRAIN;
              drain_q <= '0;
            end
          end
          ST_DRAIN: begin
            if (drain_q == DRN_LAST) state_q <= ST_DONE;
            else                     drain_q <= drain_q + 1'b1;
          end
          ST_DONE: begin
            state_q <= ST_IDLE;
          end
          default: begin
            state_q <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign tag_in = {issue, issue && w_wrap, last_issue};

  tag_pipe #(
    .DEPTH (PIPE_LAT),
    .WIDTH (TAG_W)
  ) u_tag_pipe (
    .clk     (clk),
    .rst_ni  (reset),
    .flush_i (abort),
    .tag_i   (tag_in),
    .tag_o   (tag_out)
  );

  assign en         = issue;
  assign w_row      = w_row_q;
  assign POI_row    = poi_row_q;
  assign POI_col    = poi_col_q;
  assign busy       = (state_q != ST_IDLE);
  assign done       = (state_q == ST_DONE);
  assign data_valid = tag_out[2];
  assign win_last   = tag_out[1];
  assign frame_last = tag_out[0];

endmodule

`default_nettype wire
